param_stack: RTL and testbench
==============================

Name: param_stack

Overview:
- Parameter (data) stack below the TOS register.
- Supplies pstack_top, the next-on-stack value, to the TOS combinational path and to the memory store data path.
- Accepts the current TOS as push data.
- Driven by per-instruction stack control from the decoder: push, pop, or replace.
- Parameterised so the same block can serve as the return stack (rstack_top) with a different depth.

Parameters:
- width, 16, data word width in bits; must match the TOS width.
- depth, 16, number of stack entries; must be a power of two, at least 2.
- ptr_width, $clog2(depth)+1, width of the depth counter; holds values 0..depth.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- push  input  1  push din onto the stack this cycle
- pop  input  1  pop the top entry this cycle
- din  input  width  push data; normally the current TOS
- pstack_top  output  width  top entry; 0 when empty
- sp  output  ptr_width  current number of entries
- empty  output  1  sp == 0
- full  output  1  sp == depth
- overflow  output  1  sticky: a push was dropped because the stack was full
- underflow  output  1  sticky: a pop occurred while the stack was empty
- clear_err  input  1  clears overflow and underflow

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Storage: array mem[0..depth-1] plus counter sp. Entry mem[sp-1] is the top.
- Output timing:
  - pstack_top = (sp == 0) ? 0 : mem[sp-1].
  - pstack_top is a function of registered state only. There is no combinational path from push, pop or din to any output.
  - empty and full are decoded from sp.
- Reset (synchronous, priority over everything else):
  - sp = 0, overflow = 0, underflow = 0.
  - pstack_top therefore reads 0.
  - Array contents are don't-care and are not cleared.
  - Reset asserted together with push or pop: reset wins, and the operation is discarded.
- Operations, evaluated at the rising edge when reset = 0:
  - push & ~pop, not full: mem[sp] <= din; sp <= sp+1. The new top is visible the next cycle.
  - push & ~pop, full: no write; sp unchanged; overflow <= 1.
  - pop & ~push, not empty: sp <= sp-1. Data is not cleared.
  - pop & ~push, empty: sp stays 0; underflow <= 1.
  - push & pop (replace), not empty: mem[sp-1] <= din; sp unchanged. This is legal when full.
  - push & pop (replace), empty: behaves as a plain push (mem[0] <= din, sp <= 1); no error flag.
  - Neither: hold.
- Error flags:
  - Flags are sticky until clear_err or reset.
  - clear_err and a new error in the same cycle: the flag ends up set (set wins over clear).
- Latency: every operation takes one cycle. Back-to-back operations on consecutive cycles are supported without stalls.
- Arithmetic: sp is unsigned ptr_width bits and never wraps; the saturation rules above guarantee this. The array index uses the low $clog2(depth) bits.
- The array is inferred as distributed/register storage with asynchronous read. No block RAM read latency is permitted.

Decomposition:
- Shared package holds:
  - stack op encoding constants: STK_NOP=2'b00, STK_PUSH=2'b01, STK_POP=2'b10, STK_REPL=2'b11. The decoder packs these as {pop, push}.
  - the default data width constant.
- One natural sub-module, stack_ptr: the sp counter with full/empty decode and error-flag logic.
- The storage array and read mux stay in param_stack.

Test Plan:
- Reset, then hold idle 3 cycles -> sp=0, empty=1, full=0, pstack_top=0, both flags 0.
- Push 16'h1111, 16'h2222, 16'h3333 on consecutive cycles -> sp reads 1, 2, 3 one cycle after each push; pstack_top reads 1111, 2222, 3333. Then 3 pops -> pstack_top 2222, 1111, 0; empty=1.
- With sp=2, top=16'hAAAA, assert push & pop with din=16'h5555 -> sp stays 2; pstack_top=5555; the entry below is unchanged (a following pop shows the old second entry).
- Fill with depth=16 pushes of 0..15 -> full=1, pstack_top=15. 17th push of 16'hBEEF -> sp=16, pstack_top=15, overflow=1. Replace with 16'hCAFE while full -> pstack_top=CAFE, overflow stays 1. clear_err -> overflow=0.
- Pop while empty -> underflow=1, sp=0, pstack_top=0. Next cycle, clear_err and pop together while still empty -> underflow remains 1.
- Reset mid-sequence: sp=5 and a push asserted in the same cycle as reset -> next cycle sp=0, pstack_top=0, flags 0. A subsequent push of 16'h0042 -> pstack_top=0042, sp=1.

Source files
------------

// File: rtl/param_stack_pkg.sv
// param_stack_pkg: shared stack op encoding and default data width.
package param_stack_pkg;
    localparam int DATA_WIDTH = 16;
    // Decoder packs stack control as {pop, push}.
    typedef enum logic [1:0] {
        STK_NOP  = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10,
        STK_REPL = 2'b11
    } stk_op_e;
endpackage

// File: rtl/param_stack_if.sv
// param_stack_if: control, data and status signals of a parameter/return stack.
interface param_stack_if #(
    parameter int width = 16,
    parameter int ptr_width = 5
);
    logic push;
    logic pop;
    logic clear_err;
    logic [width-1:0] din;
    logic [width-1:0] pstack_top;
    logic [ptr_width-1:0] sp;
    logic empty;
    logic full;
    logic overflow;
    logic underflow;
    modport master (
        output push, pop, clear_err, din,
        input pstack_top, sp, empty, full, overflow, underflow
    );
    modport slave (
        input push, pop, clear_err, din,
        output pstack_top, sp, empty, full, overflow, underflow
    );
endinterface

// File: rtl/param_stack_stack_ptr.sv
// stack_ptr: saturating depth counter with full/empty decode and sticky error flags.
module stack_ptr
    import param_stack_pkg::*;
#(
    parameter int depth = 16,
    parameter int ptr_width = $clog2(depth) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  stk_op_e              op,
    input  logic                 clear_err,
    output logic [ptr_width-1:0] sp,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow
);
    logic ovf_set, unf_set;
    logic [ptr_width-1:0] sp_next;
    assign empty = sp == '0;
    assign full = sp == ptr_width'(depth);
    assign ovf_set = op == STK_PUSH && full;
    assign unf_set = op == STK_POP && empty;
    // A replace on an empty stack degrades to a plain push.
    always_comb begin
        sp_next = sp;
        sp_next = ((op == STK_PUSH && !full) || (op == STK_REPL && empty)) ? sp + 1'b1 :
                  (op == STK_POP && !empty) ? sp - 1'b1 : sp;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp <= sp_next;
            overflow <= ovf_set | (overflow & ~clear_err);
            underflow <= unf_set | (underflow & ~clear_err);
        end
    end
endmodule

// File: rtl/param_stack.sv
// param_stack: register-array stack below TOS with async read of the top entry.
module param_stack
    import param_stack_pkg::*;
#(
    parameter int width = DATA_WIDTH,
    parameter int depth = 16,
    parameter int ptr_width = $clog2(depth) + 1
) (
    input logic clk,
    input logic reset,
    param_stack_if.slave bus
);
    localparam int aw = $clog2(depth);
    logic [width-1:0] mem [depth];
    stk_op_e op;
    logic [aw-1:0] top_idx, wr_idx;
    logic we;
    assign op = stk_op_e'({bus.pop, bus.push});
    stack_ptr #(.depth(depth), .ptr_width(ptr_width)) u_ptr (
        .clk(clk),
        .reset(reset),
        .op(op),
        .clear_err(bus.clear_err),
        .sp(bus.sp),
        .empty(bus.empty),
        .full(bus.full),
        .overflow(bus.overflow),
        .underflow(bus.underflow)
    );
    assign top_idx = bus.sp[aw-1:0] - 1'b1;
    assign we = !reset && ((op == STK_PUSH && !bus.full) || op == STK_REPL);
    assign wr_idx = (op == STK_REPL && !bus.empty) ? top_idx : bus.sp[aw-1:0];
    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= bus.din;
    end
    assign bus.pstack_top = bus.empty ? '0 : mem[top_idx];
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed plus random stimulus checked against a queue-based stack model.
module tb_param_stack;
    localparam int W = 16;
    localparam int D = 16;
    localparam int PW = 5;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;
    logic [W-1:0] q[$];
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;

    param_stack_if #(.width(W), .ptr_width(PW)) bus ();
    param_stack #(.width(W), .depth(D), .ptr_width(PW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] exp_top;
        exp_top = q.size() == 0 ? '0 : q[$];
        check("sp", 32'(bus.sp), 32'(q.size()));
        check("top", 32'(bus.pstack_top), 32'(exp_top));
        check("empty", 32'(bus.empty), 32'(q.size() == 0));
        check("full", 32'(bus.full), 32'(q.size() == D));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("underflow", 32'(bus.underflow), 32'(m_unf));
    endtask

    task automatic step(input logic r, input logic p, input logic po, input logic ce, input logic [W-1:0] d);
        logic e_o, e_u;
        reset = r;
        bus.push = p;
        bus.pop = po;
        bus.clear_err = ce;
        bus.din = d;
        @(posedge clk);
        e_o = 1'b0;
        e_u = 1'b0;
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && po) begin
                if (q.size() == 0) q.push_back(d);
                else q[q.size()-1] = d;
            end else if (p) begin
                if (q.size() == D) e_o = 1'b1;
                else q.push_back(d);
            end else if (po) begin
                if (q.size() == 0) e_u = 1'b1;
                else void'(q.pop_back());
            end
            m_ovf = e_o | (m_ovf & ~ce);
            m_unf = e_u | (m_unf & ~ce);
        end
        #1;
        check_all();
    endtask

    initial begin
        int thr;
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0);
        step(0, 1, 0, 0, 16'h1111);
        step(0, 1, 0, 0, 16'h2222);
        step(0, 1, 0, 0, 16'h3333);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0);
        step(0, 1, 0, 0, 16'h7777);
        step(0, 1, 0, 0, 16'hAAAA);
        step(0, 1, 1, 0, 16'h5555);
        step(0, 0, 1, 0, '0);
        step(0, 0, 1, 0, '0);
        for (int i = 0; i < D; i++) step(0, 1, 0, 0, W'(i));
        step(0, 1, 0, 0, 16'hBEEF);
        step(0, 1, 1, 0, 16'hCAFE);
        step(0, 0, 0, 1, '0);
        for (int i = 0; i < D; i++) step(0, 0, 1, 0, '0);
        step(0, 0, 1, 0, '0);
        step(0, 0, 1, 1, '0);
        step(0, 1, 1, 0, 16'h0BAD);
        step(0, 0, 0, 1, '0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, W'(16'h0100 + i));
        step(1, 1, 0, 0, 16'hDEAD);
        step(0, 1, 0, 0, 16'h0042);
        for (int i = 0; i < 400; i++) begin
            thr = ((i / 40) % 2 == 0) ? 75 : 25;
            step(($urandom % 97) == 0,
                 ($urandom % 100) < 32'(thr),
                 ($urandom % 100) < 32'(100 - thr),
                 ($urandom % 8) == 0,
                 W'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
